commit_trace_buffer: RTL and testbench
======================================

# commit_trace_buffer

Consumer for the CPU's commit debug interface. It captures each newly retired commit record into a FIFO and serialises the records as 32-bit words over a valid/ready stream to the debug host. It raises a stall request so the top level can gate `global_en`. It also latches halt, counts commits and flags overflow. It sits beside the CPU at the top level, fed by the `commit_*` outputs and the same `global_en`.

## Interface
Parameters:
- DEPTH, 16, FIFO depth in records; power of two, ≥4.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- global_en  in  1  same enable the CPU samples.
- commit, commit_halt, commit_reg_we, commit_dmem_we  in  1 each  CPU commit fields.
- commit_pc, commit_inst, commit_reg_wd, commit_dmem_wa, commit_dmem_wd  in  32 each  CPU commit fields.
- commit_reg_wa  in  5  CPU commit field.
- trace_valid  out  1  word available.
- trace_ready  in  1  host accepts word.
- trace_data  out  32  current word.
- trace_last  out  1  final word of a record.
- stall_req  out  1  request to deassert `global_en`.
- halted  out  1  halt record seen (sticky).
- overflow  out  1  a record was dropped (sticky).
- commit_cnt  out  32  qualified commits seen.
- drop_cnt  out  16  records dropped.

## Operation
- The CPU commit registers hold their value while `global_en` is low. Capture is therefore qualified by `en_q`, which is `global_en` registered.
  - A record is **qualified** when `commit && en_q && !halted`.
- A qualified record increments `commit_cnt`, which wraps modulo 2^32.
- Push the record if `count < DEPTH` or a pop happens on the same edge. Otherwise drop it: `overflow` is set and `drop_cnt` increments, saturating at 0xFFFF.
- A qualified record with `commit_halt=1` sets `halted`, whether or not that record was pushed or dropped. Further records are ignored: no count, no drop. Draining continues. Only `rst` clears `halted`.
- Record word order:
  - W0 = pc.
  - W1 = inst.
  - W2 = {halt[31], reg_we[30], dmem_we[29], 24'b0, reg_wa[4:0]}.
  - W3 = reg_wd.
  - W4 = dmem_wa.
  - W5 = dmem_wd.
- Serialiser: a word index `widx` runs 0..NW-1 over the FIFO head.
  - `trace_valid = !empty`.
  - `trace_data` = the head word selected by `widx`.
  - `trace_last = (widx == NW-1)`.
  - When `trace_valid && trace_ready`: if not last, `widx` increments; if last, `widx` returns to 0 and the head record is popped.
- `stall_req = (count >= DEPTH-1)`. Registered enable gives at most one record in flight, so no drop occurs when the top level honours the stall.
- Serialiser states:
  - IDLE (empty).
  - SEND (widx 0..NW-1).
  - SEND → IDLE on the last handshake with the FIFO then empty.
  - SEND → SEND with `widx=0` when more records remain.

## Timing
- Reset values: all outputs 0, `en_q=0`, FIFO empty, `widx=0`.
  - `rst` asserted mid-record discards the partial record immediately.
  - `trace_valid` falls asynchronously on `rst`.
- A record captured at edge t gives `trace_valid=1` in the cycle after t. There is no bypass, so latency is 1 cycle.
- `trace_data` must remain stable while `trace_valid && !trace_ready`.
- Full FIFO with a simultaneous push and a pop on the last word: both succeed and `count` is unchanged.
- Empty FIFO with a push: the record is not visible until the next cycle.
- `stall_req`, `halted`, `overflow` and the counters are all registered-state derived. They reflect edge t in the cycle after t.

## Configuration
- `TRACE_DMEM_EN` defined: NW=6. The dmem fields are stored and W4/W5 are sent.
- `TRACE_DMEM_EN` undefined: NW=4. `dmem_wa`/`dmem_wd` are neither stored nor sent, and W2 bit 29 is still driven from `commit_dmem_we`.

## Structure
- Package `commit_trace_pkg` holds:
  - word-index constants W_PC..W_DWD;
  - NW, derived from `TRACE_DMEM_EN`;
  - W2 flag bit positions;
  - the packed record typedef.
- Sub-module `trace_fifo`: a synchronous FIFO with DEPTH entries of the record type, push/pop/full/empty/count, and asynchronous reset.

## Test plan
- Single record pc=0x1C000000, inst=0x02800421, reg_we=1, wa=1, wd=0x5, `trace_ready=1` → words 0x1C000000, 0x02800421, 0x40000001, 0x00000005, …, `trace_last` on word NW-1, `commit_cnt=1`.
- `global_en` low for 5 cycles with `commit=1` held → exactly one record captured; `commit_cnt` unchanged during the hold.
- `trace_ready=0`, DEPTH+2 records pushed with the top-level stall ignored → `stall_req` at count 15, `overflow=1`, `drop_cnt=2`, the first 16 records intact and in order.
- Halt record inst=0x80000000 followed by 3 more commits → `halted=1`, `commit_cnt` stops at the halt, the halt record is drained with W2[31]=1.
- `trace_ready` toggling every cycle mid-record → no word duplicated or skipped, and data stable while stalled.
- `rst` pulsed mid-word 2 → all outputs 0 immediately; the next record starts at W0.

Source files
------------

// File: rtl/commit_trace_buffer_pkg.sv
// commit_trace_pkg: shared definitions for the commit trace buffer.
//   - word-index constants W_PC..W_DWD and the number of words per record (NW)
//   - W2 flag bit positions
//   - the packed record stored in the FIFO
//   - rec_word(): selects one 32-bit word of a record
// Configuration macro: TRACE_DMEM_EN
//   defined   -> NW=6; the dmem address and data are stored and sent as W4/W5
//   undefined -> NW=4; the dmem address and data are neither stored nor sent
package commit_trace_pkg;

`ifdef TRACE_DMEM_EN
    localparam int NW = 6;
`else
    localparam int NW = 4;
`endif

    localparam logic [2:0] W_PC    = 3'd0;
    localparam logic [2:0] W_INST  = 3'd1;
    localparam logic [2:0] W_FLAGS = 3'd2;
    localparam logic [2:0] W_RWD   = 3'd3;
    localparam logic [2:0] W_DWA   = 3'd4;
    localparam logic [2:0] W_DWD   = 3'd5;
    localparam logic [2:0] W_LAST  = 3'(NW - 1);

    localparam int F_HALT    = 31;
    localparam int F_REG_WE  = 30;
    localparam int F_DMEM_WE = 29;

    typedef struct packed {
        logic        halt;
        logic        reg_we;
        logic        dmem_we;
        logic [4:0]  reg_wa;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] reg_wd;
`ifdef TRACE_DMEM_EN
        logic [31:0] dmem_wa;
        logic [31:0] dmem_wd;
`endif
    } trace_rec_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_t;

    // Word idx of record r; indices beyond NW-1 read as zero.
    function automatic logic [31:0] rec_word(input trace_rec_t r, input logic [2:0] idx);
        logic [31:0] w;
        w = 32'h0000_0000;
        case (idx)
            W_PC:    w = r.pc;
            W_INST:  w = r.inst;
            W_FLAGS: begin
                w[F_HALT]    = r.halt;
                w[F_REG_WE]  = r.reg_we;
                w[F_DMEM_WE] = r.dmem_we;
                w[4:0]       = r.reg_wa;
            end
            W_RWD:   w = r.reg_wd;
`ifdef TRACE_DMEM_EN
            W_DWA:   w = r.dmem_wa;
            W_DWD:   w = r.dmem_wd;
`endif
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// commit_trace_buffer_if: valid/ready word stream towards the debug host.
//   valid : word available        (master -> slave)
//   data  : current 32-bit word    (master -> slave)
//   last  : final word of a record (master -> slave)
//   ready : host accepts the word  (slave -> master)
interface commit_trace_buffer_if;
    logic        valid;
    logic        ready;
    logic        last;
    logic [31:0] data;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/commit_trace_buffer_fifo.sv
// trace_fifo: synchronous FIFO of DEPTH commit records (DEPTH a power of two).
//   clk, rst     : clock, asynchronous active-high reset (FIFO becomes empty)
//   push, wdata  : write a record; the caller only pushes when !full or when popping
//   pop, rdata   : head record (rdata) and its removal on pop
//   full, empty  : occupancy flags
//   count        : number of stored records, 0..DEPTH
module trace_fifo
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  trace_rec_t               wdata,
    input  logic                     pop,
    output trace_rec_t               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    trace_rec_t    mem_q [DEPTH];

    // Next pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Record storage; on a full push+pop the write lands in the slot being freed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: captures retired commit records from the CPU into a FIFO
// and serialises them as 32-bit words (NW per record) to the debug host.
//   clk, rst          : clock, asynchronous active-high reset
//   global_en         : CPU enable; registered (en_q) to qualify commits
//   commit_*          : CPU commit record fields
//   trace (master)    : valid/ready word stream with last-word marker
//   stall_req         : FIFO near full, top level should drop global_en
//   halted            : sticky, a halt record was seen
//   overflow          : sticky, a record was dropped
//   commit_cnt        : qualified commits, wraps
//   drop_cnt          : dropped records, saturates at 0xFFFF
// Configuration macro: TRACE_DMEM_EN (adds dmem address/data words W4/W5).
module commit_trace_buffer
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          global_en,
    input  logic                          commit,
    input  logic                          commit_halt,
    input  logic                          commit_reg_we,
    input  logic                          commit_dmem_we,
    input  logic [31:0]                   commit_pc,
    input  logic [31:0]                   commit_inst,
    input  logic [31:0]                   commit_reg_wd,
    input  logic [31:0]                   commit_dmem_wa,
    input  logic [31:0]                   commit_dmem_wd,
    input  logic [4:0]                    commit_reg_wa,
    commit_trace_buffer_if.master         trace,
    output logic                          stall_req,
    output logic                          halted,
    output logic                          overflow,
    output logic [31:0]                   commit_cnt,
    output logic [15:0]                   drop_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic        en_q, en_d;
    logic        halted_q, halted_d;
    logic        overflow_q, overflow_d;
    logic [31:0] commit_cnt_q, commit_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [2:0]  widx_q, widx_d;
    ser_state_t  state_q, state_d;

    logic        qual_s, hs_s, last_s, pop_s, push_s, drop_s;
    logic        full_s, empty_s;
    logic [CW-1:0] count_s;
    trace_rec_t  wrec_s, head_s;

`ifndef TRACE_DMEM_EN
    logic unused_dmem_s;
    assign unused_dmem_s = ^{commit_dmem_wa, commit_dmem_wd};
`endif

    // Capture qualification; a pop on the last word frees a slot for a same-edge push.
    always_comb begin
        qual_s = commit && en_q && !halted_q;
        hs_s   = !empty_s && trace.ready;
        last_s = (widx_q == W_LAST);
        pop_s  = hs_s && last_s;
        push_s = qual_s && (!full_s || pop_s);
        drop_s = qual_s && !push_s;
    end

    // Record assembly from the commit fields.
    always_comb begin
        wrec_s         = '0;
        wrec_s.halt    = commit_halt;
        wrec_s.reg_we  = commit_reg_we;
        wrec_s.dmem_we = commit_dmem_we;
        wrec_s.reg_wa  = commit_reg_wa;
        wrec_s.pc      = commit_pc;
        wrec_s.inst    = commit_inst;
        wrec_s.reg_wd  = commit_reg_wd;
`ifdef TRACE_DMEM_EN
        wrec_s.dmem_wa = commit_dmem_wa;
        wrec_s.dmem_wd = commit_dmem_wd;
`endif
    end

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata (wrec_s),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Status and counters; halt is latched even when its own record was dropped.
    always_comb begin
        en_d         = global_en;
        commit_cnt_d = commit_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        overflow_d   = overflow_q;
        halted_d     = halted_q;
        if (qual_s) begin
            commit_cnt_d = commit_cnt_q + 32'd1;
            halted_d     = halted_q | commit_halt;
        end else begin
            commit_cnt_d = commit_cnt_q;
            halted_d     = halted_q;
        end
        if (drop_s) begin
            overflow_d = 1'b1;
            drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
        end else begin
            overflow_d = overflow_q;
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Serialiser next state and word index.
    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        case (state_q)
            S_IDLE: begin
                widx_d = 3'd0;
                if (push_s) begin
                    state_d = S_SEND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                if (hs_s) begin
                    if (last_s) begin
                        widx_d = 3'd0;
                        // Popping the only record with nothing arriving empties the FIFO.
                        if ((count_s == CW'(1)) && !push_s) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_SEND;
                        end
                    end else begin
                        widx_d  = widx_q + 3'd1;
                        state_d = S_SEND;
                    end
                end else begin
                    widx_d  = widx_q;
                    state_d = S_SEND;
                end
            end
            default: begin
                state_d = S_IDLE;
                widx_d  = 3'd0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q         <= 1'b0;
            halted_q     <= 1'b0;
            overflow_q   <= 1'b0;
            commit_cnt_q <= 32'd0;
            drop_cnt_q   <= 16'd0;
            widx_q       <= 3'd0;
            state_q      <= S_IDLE;
        end else begin
            en_q         <= en_d;
            halted_q     <= halted_d;
            overflow_q   <= overflow_d;
            commit_cnt_q <= commit_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            widx_q       <= widx_d;
            state_q      <= state_d;
        end
    end

    // Data is forced to zero while empty so reset shows all-zero outputs.
    assign trace.valid = !empty_s;
    assign trace.data  = empty_s ? 32'h0000_0000 : rec_word(head_s, widx_q);
    assign trace.last  = !empty_s && last_s;

    assign stall_req  = (count_s >= CW'(DEPTH - 1));
    assign halted     = halted_q;
    assign overflow   = overflow_q;
    assign commit_cnt = commit_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: a reference model derives the
// expected word stream and status from the commit rules, a monitor checks.
module tb_commit_trace_buffer;
    import commit_trace_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        global_en = 1'b0;
    logic        commit = 1'b0, commit_halt = 1'b0, commit_reg_we = 1'b0, commit_dmem_we = 1'b0;
    logic [31:0] commit_pc = 32'h0, commit_inst = 32'h0, commit_reg_wd = 32'h0;
    logic [31:0] commit_dmem_wa = 32'h0, commit_dmem_wd = 32'h0;
    logic [4:0]  commit_reg_wa = 5'h0;
    logic        stall_req, halted, overflow;
    logic [31:0] commit_cnt;
    logic [15:0] drop_cnt;

    commit_trace_buffer_if trace_bus();

    commit_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .global_en(global_en),
        .commit(commit), .commit_halt(commit_halt), .commit_reg_we(commit_reg_we),
        .commit_dmem_we(commit_dmem_we), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .commit_reg_wd(commit_reg_wd), .commit_dmem_wa(commit_dmem_wa),
        .commit_dmem_wd(commit_dmem_wd), .commit_reg_wa(commit_reg_wa),
        .trace(trace_bus), .stall_req(stall_req), .halted(halted), .overflow(overflow),
        .commit_cnt(commit_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [32:0] exp_q[$];     // {last, word}
    int          m_recs;       // records held
    int          m_sent;       // words of the head record already accepted
    logic        m_en_q, m_halted, m_ovf;
    logic [31:0] m_cnt;
    int          m_drop;

    task automatic m_reset();
        exp_q.delete();
        m_recs = 0; m_sent = 0; m_en_q = 1'b0; m_halted = 1'b0; m_ovf = 1'b0;
        m_cnt = 32'h0; m_drop = 0;
    endtask

    task automatic m_step();
        logic [31:0] w [6];
        bit hs, pop, qual;
        hs   = (m_recs > 0) && (trace_bus.ready === 1'b1);
        pop  = hs && (m_sent == NW - 1);
        if (hs) m_sent = pop ? 0 : m_sent + 1;
        qual = commit && m_en_q && !m_halted;
        if (qual) begin
            m_cnt = m_cnt + 32'd1;
            if (m_recs < DEPTH || pop) begin
                w[0] = commit_pc;
                w[1] = commit_inst;
                w[2] = {commit_halt, commit_reg_we, commit_dmem_we, 24'h0, commit_reg_wa};
                w[3] = commit_reg_wd;
                w[4] = commit_dmem_wa;
                w[5] = commit_dmem_wd;
                for (int i = 0; i < NW; i++) exp_q.push_back({(i == NW - 1), w[i]});
                m_recs++;
            end else begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end
            if (commit_halt) m_halted = 1'b1;
        end
        if (pop) m_recs--;
        m_en_q = global_en;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    // ---------------- monitor ----------------
    logic        prev_stalled = 1'b0;
    logic [31:0] prev_data    = 32'h0;

    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stalled = 1'b0;
            end else begin
                check("valid", 32'(trace_bus.valid), 32'(m_recs != 0));
                check("commit_cnt", commit_cnt, m_cnt);
                check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
                check("overflow", 32'(overflow), 32'(m_ovf));
                check("halted", 32'(halted), 32'(m_halted));
                check("stall_req", 32'(stall_req), 32'(m_recs >= DEPTH - 1));
                if (prev_stalled && trace_bus.valid) check("data_stable", trace_bus.data, prev_data);
                if (trace_bus.valid && trace_bus.ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_word: got 0x%08h expected no word", trace_bus.data);
                    end else begin
                        e = exp_q.pop_front();
                        check("data", trace_bus.data, e[31:0]);
                        check("last", 32'(trace_bus.last), 32'(e[32]));
                    end
                end
                prev_stalled = trace_bus.valid && !trace_bus.ready;
                prev_data    = trace_bus.data;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_rec(input logic halt, input logic [31:0] pc, input logic [31:0] inst);
        commit         = 1'b1;
        commit_halt    = halt;
        commit_pc      = pc;
        commit_inst    = inst;
        commit_reg_we  = 1'($urandom_range(0, 1));
        commit_dmem_we = 1'($urandom_range(0, 1));
        commit_reg_wa  = 5'($urandom);
        commit_reg_wd  = $urandom;
        commit_dmem_wa = $urandom;
        commit_dmem_wd = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(trace_bus.valid), 32'h0);
        check({tag, "_data"}, trace_bus.data, 32'h0);
        check({tag, "_last"}, 32'(trace_bus.last), 32'h0);
        check({tag, "_stall"}, 32'(stall_req), 32'h0);
        check({tag, "_halted"}, 32'(halted), 32'h0);
        check({tag, "_overflow"}, 32'(overflow), 32'h0);
        check({tag, "_cnt"}, commit_cnt, 32'h0);
        check({tag, "_drop"}, 32'(drop_cnt), 32'h0);
    endtask

    task automatic drain();
        int b;
        commit = 1'b0;
        trace_bus.ready = 1'b1;
        b = 0;
        while (trace_bus.valid && b < 500) begin
            tick();
            b++;
        end
        tick();
        check("drained", 32'(trace_bus.valid), 32'h0);
        check("exp_left", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        trace_bus.ready = 1'b0;
        #12;
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        global_en = 1'b1;
        trace_bus.ready = 1'b1;
        tick();

        // single directed record
        set_rec(1'b0, 32'h1C00_0000, 32'h0280_0421);
        commit_reg_we = 1'b1; commit_dmem_we = 1'b0;
        commit_reg_wa = 5'd1; commit_reg_wd = 32'h5;
        tick();
        commit = 1'b0;
        repeat (NW + 3) tick();

        // commit held while global_en low for 5 cycles
        set_rec(1'b0, 32'h1C00_0004, $urandom);
        global_en = 1'b0;
        repeat (5) tick();
        commit = 1'b0;
        global_en = 1'b1;
        drain();

        // overflow: DEPTH+2 records with the host stalled
        trace_bus.ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            set_rec(1'b0, 32'h2000_0000 + 32'(i * 4), $urandom);
            tick();
        end
        commit = 1'b0;
        repeat (3) tick();
        drain();

        // ready toggling every cycle
        for (int i = 0; i < 40; i++) begin
            trace_bus.ready = ~trace_bus.ready;
            if (i % 10 == 1) set_rec(1'b0, $urandom, $urandom);
            else commit = 1'b0;
            tick();
        end
        drain();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1) set_rec(1'b0, $urandom, $urandom);
            else commit = 1'b0;
            global_en = ($urandom_range(0, 4) != 0);
            trace_bus.ready = 1'($urandom_range(0, 1));
            tick();
        end
        global_en = 1'b1;
        drain();

        // reset in the middle of word 2
        trace_bus.ready = 1'b0;
        set_rec(1'b0, 32'h3000_0000, $urandom);
        tick();
        commit = 1'b0;
        tick();
        trace_bus.ready = 1'b1;
        tick();
        tick();
        #1 rst = 1'b1;
        #1 check_all_zero("midrst");
        tick();
        rst = 1'b0;
        tick();
        set_rec(1'b0, 32'h3000_0100, $urandom);
        tick();
        commit = 1'b0;
        drain();

        // halt record followed by three more commits
        set_rec(1'b1, 32'h4000_0000, 32'h8000_0000);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_rec(1'b0, 32'h4000_0004 + 32'(i * 4), $urandom);
            tick();
        end
        commit = 1'b0;
        drain();
        check("final_halted", 32'(halted), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
